seg_display_arbiter: RTL
========================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display among NREQ requesters.
//  Round-robin arbitration with a minimum on-screen hold time.
//  Sits between the producer blocks and the 7-seg scan driver; disp_x feeds the driver's 16-bit hex input.
//  Only one requester's value is shown at a time; grant tells each producer when it owns the display.
// PARAMETERS
//  NREQ         4            number of requesters (2..8)
//  HOLD_CYCLES  100_000_000  minimum clk cycles a grant is kept while others wait (1 s @ 100 MHz)
//  CNT_W        27           hold-timer width; must hold HOLD_CYCLES-1
//  SRC_W        2            width of disp_src; equals clog2(NREQ)
// PORTS
//  clk          in   1         system clock; all logic on posedge
//  rst_n        in   1         asynchronous active-low reset
//  req          in   NREQ      req[i]=1: requester i wants the display; level, held while wanted
//  req_data     in   16*NREQ   req_data[16*i+:16] = hex value of requester i
//  grant        out  NREQ      one-hot owner, or all zero; registered
//  disp_x       out  16        value for the scan driver; registered
//  disp_src     out  SRC_W     index of current or last owner
//  disp_valid   out  1         1 while some grant is active
//  switch_p     out  1         one-cycle pulse on each new grant (owner change or first grant)
// BEHAVIOUR
//  Reset values: grant=0, disp_x=16'h0000, disp_src=0, disp_valid=0, switch_p=0, timer=0, state=IDLE.
//  States: IDLE (no owner), SHOW (owner = disp_src). Registered state.
//  Round-robin pick: first i with req[i]=1, searching disp_src+1, disp_src+2, ... wrapping modulo NREQ.
//   disp_src itself is the last candidate.
//  IDLE, any req set:
//   - next cycle: grant = onehot(pick), disp_src = pick, timer = HOLD_CYCLES-1;
//   - switch_p = 1, disp_valid = 1; state -> SHOW.
//  IDLE, no req: outputs hold. disp_x keeps the last shown value; the display is never blanked.
//  SHOW, each cycle: disp_x <= req_data[owner]. disp_x lags req_data by one cycle.
//   timer decrements while > 0.
//  SHOW, owner drops req: release takes priority over the timer.
//   - another req pending: switch to pick next cycle, reload timer, switch_p = 1;
//   - none pending: state -> IDLE, grant = 0, disp_valid = 0; disp_src keeps its value.
//  SHOW, timer == 0 and another requester pending: switch to pick; reload timer; switch_p = 1.
//  SHOW, timer == 0 and only the owner requesting: keep the grant; reload timer; switch_p = 0.
//  On a switch, disp_x loads req_data of the new owner in the same edge as grant changes.
//  Grant latency: 1 cycle from req sampled to grant. No combinational path from req to grant.
//  Starvation bound: a waiting requester is granted within (NREQ-1)*HOLD_CYCLES+1 cycles.
//  Simultaneous requests: resolved only by round-robin order; no fixed priority.
//  rst_n asserted mid-SHOW: all outputs go to their reset values immediately (async).
//   After release, the first pick searches from index 1 (disp_src=0).
//  HOLD_CYCLES=1: timer is always 0; arbitration runs every cycle.
// STRUCTURE
//  Shared package seg_pkg:
//   - state encoding localparams ST_IDLE / ST_SHOW;
//   - DIGIT_W = 16;
//   - default hold constant HOLD_1S = 100_000_000.
//  Sub-module rr_pick: combinational; inputs (req, last); outputs (pick, any).
//   Implemented as a rotate, then priority encode, then rotate back.
//  Top level: state register, hold timer, output registers, req_data mux.
// TESTING  (use HOLD_CYCLES=8, NREQ=4)
//  1. Reset released, req=0 for 20 cycles -> grant=0, disp_valid=0, disp_x=0000, switch_p never 1.
//  2. req=4'b0100, data2=16'h1234 -> grant=0100 on the 1st edge after req, switch_p for 1 cycle,
//     disp_src=2, disp_x=1234; held indefinitely.
//  3. req=4'b1111 from IDLE with disp_src=0 -> grant sequence 0010,0100,1000,0001;
//     each grant lasts exactly 8 cycles.
//  4. Owner 1 granted; req[1] drops at cycle 3 of its hold while req[3]=1 -> grant=1000 next cycle.
//   Timer reloads.
//  5. Owner 2 alone for 30 cycles; data2 changes 0000->ABCD -> disp_x=ABCD one cycle later.
//   No switch_p after the first pulse.
//  6. rst_n pulsed low mid-SHOW -> grant, disp_x, disp_valid go to 0 without waiting for a clk edge.
//   With req=4'b1001 after reset, the first grant is 1000.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and state encoding for the 7-seg arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

   localparam int DIGIT_W = 16;
   localparam int HOLD_1S = 100_000_000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   function automatic logic [7:0] onehot8(input int idx);
      logic [7:0] v;
      v = '0;
      v[idx[2:0]] = 1'b1;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, searching from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NREQ  = 4,
   parameter int SRC_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [SRC_W-1:0] last,
   output logic [SRC_W-1:0] pick,
   output logic             any
);

   logic [NREQ-1:0] rot;
   int              ofs;

   function automatic logic [SRC_W-1:0] wrap(input int v);
      return SRC_W'(v % NREQ);
   endfunction

   // rot[0] is the candidate right after last; last itself lands at rot[NREQ-1]
   always_comb begin
      rot = '0;
      for (int k = 0; k < NREQ; k++) begin
         rot[k] = req[wrap(int'(last) + 1 + k)];
      end
      ofs = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) ofs = k;
      end
      pick = wrap(int'(last) + 1 + ofs);
      any  = |req;
   end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin sharing of one 4-digit 7-seg display, min hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = HOLD_1S,
   parameter int CNT_W       = 27,
   parameter int SRC_W       = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [DIGIT_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]         grant,
   output logic [DIGIT_W-1:0]      disp_x,
   output logic [SRC_W-1:0]        disp_src,
   output logic                    disp_valid,
   output logic                    switch_p
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     timer, timer_nx;
   logic [NREQ-1:0]      grant_nx;
   logic [SRC_W-1:0]     src_nx;
   logic                 valid_nx;
   logic                 switch_nx;
   logic [DIGIT_W-1:0]   disp_nx;
   logic [SRC_W-1:0]     pick;
   logic                 any;
   logic                 owner_req;
   logic                 others;
   logic                 take;

   rr_pick #(
      .NREQ  (NREQ),
      .SRC_W (SRC_W)
   ) u_pick (
      .req  (req),
      .last (disp_src),
      .pick (pick),
      .any  (any)
   );

   assign owner_req = |(req & grant);
   assign others    = |(req & ~grant);

   always_comb begin
      state_nx  = state;
      timer_nx  = timer;
      grant_nx  = grant;
      src_nx    = disp_src;
      valid_nx  = disp_valid;
      switch_nx = 1'b0;
      disp_nx   = disp_x;
      take      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (any) take = 1'b1;
         end
         ST_SHOW: begin
            // owner release wins over the hold timer
            if (!owner_req) begin
               if (any) begin
                  take = 1'b1;
               end else begin
                  state_nx = ST_IDLE;
                  grant_nx = '0;
                  valid_nx = 1'b0;
               end
            end else if (timer == '0) begin
               if (others) take = 1'b1;
               else        timer_nx = RELOAD;
            end else begin
               timer_nx = timer - 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      if (take) begin
         state_nx  = ST_SHOW;
         grant_nx  = NREQ'(onehot8(int'(pick)));
         src_nx    = pick;
         timer_nx  = RELOAD;
         valid_nx  = 1'b1;
         switch_nx = 1'b1;
      end

      // the last owner's value is kept on screen while idle
      if (state_nx == ST_SHOW || state == ST_SHOW) begin
         disp_nx = req_data[DIGIT_W*int'(src_nx) +: DIGIT_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         timer      <= '0;
         grant      <= '0;
         disp_x     <= '0;
         disp_src   <= '0;
         disp_valid <= 1'b0;
         switch_p   <= 1'b0;
      end else begin
         state      <= state_nx;
         timer      <= timer_nx;
         grant      <= grant_nx;
         disp_x     <= disp_nx;
         disp_src   <= src_nx;
         disp_valid <= valid_nx;
         switch_p   <= switch_nx;
      end
   end

endmodule

`default_nettype wire
